// File: rtl/conway_life_engine.sv
// Game of Life core: a W x H register grid evaluated one cell per clock, with a
// double-buffered grid so the display read port only ever sees complete generations.
module conway_life_engine #(
  parameter int W    = 16,
  parameter int H    = 16,
  parameter int WRAP = 1,
  parameter int XW   = $clog2(W),
  parameter int YW   = $clog2(H)
) (
  input  logic           board_clk,
  input  logic           reset,
  input  logic           step,
  input  logic           run,
  input  logic           gen_tick,
  input  logic           clear,
  input  logic           seed_we,
  input  logic [XW-1:0]  seed_x,
  input  logic [YW-1:0]  seed_y,
  input  logic           seed_val,
  input  logic [XW-1:0]  rd_x,
  input  logic [YW-1:0]  rd_y,
  output logic           rd_alive,
  output logic           busy,
  output logic           gen_done,
  output logic [15:0]    generation,
  output logic [XW+YW:0] pop_count
);

  localparam int N  = W * H;
  localparam int IW = $clog2(N);
  localparam int PW = XW + YW + 1;
  localparam logic [XW-1:0] X_LAST = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(H - 1);
  localparam logic [XW:0]   X_LIM  = (XW + 1)'(W);
  localparam logic [YW:0]   Y_LIM  = (YW + 1)'(H);

  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  cur_q, cur_d;
  logic [N-1:0]  nxt_q, nxt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] pop_q, pop_d;
  logic [15:0]   gen_q, gen_d;
  logic          rd_alive_q, rd_alive_d;

  logic          start;
  logic          seed_ok, rd_ok;
  logic [IW-1:0] seed_idx, rd_idx, cell_idx;
  logic [3:0]    n_count;
  logic          cell_new;
  int            nb_x [3];
  int            nb_y [3];
  logic          nb_x_ok [3];
  logic          nb_y_ok [3];

  // Neighbour sum for the scan cell; with WRAP=0 the off-grid side is masked out.
  always_comb begin
    nb_x[0]    = (x_q == '0) ? W - 1 : int'(x_q) - 1;
    nb_x[1]    = int'(x_q);
    nb_x[2]    = (x_q == X_LAST) ? 0 : int'(x_q) + 1;
    nb_y[0]    = (y_q == '0) ? H - 1 : int'(y_q) - 1;
    nb_y[1]    = int'(y_q);
    nb_y[2]    = (y_q == Y_LAST) ? 0 : int'(y_q) + 1;
    nb_x_ok[0] = (WRAP != 0) || (x_q != '0);
    nb_x_ok[1] = 1'b1;
    nb_x_ok[2] = (WRAP != 0) || (x_q != X_LAST);
    nb_y_ok[0] = (WRAP != 0) || (y_q != '0);
    nb_y_ok[1] = 1'b1;
    nb_y_ok[2] = (WRAP != 0) || (y_q != Y_LAST);
    n_count    = '0;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        if (!(dx == 1 && dy == 1) && nb_x_ok[dx] && nb_y_ok[dy]) begin
          n_count = n_count + {3'b000, cur_q[IW'(nb_y[dy] * W + nb_x[dx])]};
        end
      end
    end
    cell_idx = IW'(int'(y_q) * W + int'(x_q));
    cell_new = (n_count == 4'd3) || (cur_q[cell_idx] && (n_count == 4'd2));
  end

  always_comb begin
    start      = step | (run & gen_tick);
    seed_ok    = ({1'b0, seed_x} < X_LIM) && ({1'b0, seed_y} < Y_LIM);
    rd_ok      = ({1'b0, rd_x} < X_LIM) && ({1'b0, rd_y} < Y_LIM);
    seed_idx   = IW'(int'(seed_y) * W + int'(seed_x));
    rd_idx     = IW'(int'(rd_y) * W + int'(rd_x));

    state_d    = state_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    x_d        = x_q;
    y_d        = y_q;
    acc_d      = acc_q;
    pop_d      = pop_q;
    gen_d      = gen_q;
    rd_alive_d = rd_ok ? cur_q[rd_idx] : 1'b0;

    // Clear aborts anything in flight; a seed write blocks a same-cycle start.
    if (clear) begin
      state_d = IDLE;
      cur_d   = '0;
      x_d     = '0;
      y_d     = '0;
      acc_d   = '0;
      pop_d   = '0;
      gen_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (seed_we) begin
            if (seed_ok) begin
              cur_d[seed_idx] = seed_val;
            end
          end else if (start) begin
            state_d = COMPUTE;
            x_d     = '0;
            y_d     = '0;
            acc_d   = '0;
          end
        end
        COMPUTE: begin
          nxt_d[cell_idx] = cell_new;
          acc_d           = acc_q + PW'(cell_new);
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              state_d = COMMIT;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
        COMMIT: begin
          cur_d   = nxt_q;
          gen_d   = gen_q + 16'd1;
          pop_d   = acc_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      nxt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      acc_q      <= '0;
      pop_q      <= '0;
      gen_q      <= '0;
      rd_alive_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      acc_q      <= acc_d;
      pop_q      <= pop_d;
      gen_q      <= gen_d;
      rd_alive_q <= rd_alive_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign gen_done   = (state_q == COMMIT);
  assign rd_alive   = rd_alive_q;
  assign generation = gen_q;
  assign pop_count  = pop_q;

endmodule

// File: tb/tb_conway_life_engine.sv
// Bench for conway_life_engine: a toroidal and a dead-edge instance share stimulus
// and are both compared against a 2D-array Game of Life model.
module tb_conway_life_engine;

  localparam int W = 16;
  localparam int H = 16;

  logic       board_clk = 1'b0;
  logic       reset, step, run, gen_tick, clear, seed_we, seed_val;
  logic [3:0] seed_x, seed_y, rd_x, rd_y;
  logic       rd_alive_w, busy_w, gen_done_w;
  logic       rd_alive_n, busy_n, gen_done_n;
  logic [15:0] generation_w, generation_n;
  logic [8:0]  pop_w, pop_n;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: index 0 models the toroidal build, index 1 the dead-edge build.
  bit ref_grid [2][H][W];
  int ref_gen  [2];
  int ref_pop  [2];

  typedef struct {
    string       name;
    int          ncells;
    logic [39:0] cells;
    int          steps;
    int          pop_wrap;
    int          pop_nowrap;
  } vec_t;

  vec_t vecs [7];

  always #5 board_clk = ~board_clk;

  conway_life_engine #(.W(W), .H(H), .WRAP(1)) u_dut_wrap (
    .board_clk(board_clk), .reset(reset), .step(step), .run(run), .gen_tick(gen_tick),
    .clear(clear), .seed_we(seed_we), .seed_x(seed_x), .seed_y(seed_y), .seed_val(seed_val),
    .rd_x(rd_x), .rd_y(rd_y), .rd_alive(rd_alive_w), .busy(busy_w), .gen_done(gen_done_w),
    .generation(generation_w), .pop_count(pop_w)
  );

  conway_life_engine #(.W(W), .H(H), .WRAP(0)) u_dut_nowrap (
    .board_clk(board_clk), .reset(reset), .step(step), .run(run), .gen_tick(gen_tick),
    .clear(clear), .seed_we(seed_we), .seed_x(seed_x), .seed_y(seed_y), .seed_val(seed_val),
    .rd_x(rd_x), .rd_y(rd_y), .rd_alive(rd_alive_n), .busy(busy_n), .gen_done(gen_done_n),
    .generation(generation_n), .pop_count(pop_n)
  );

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge board_clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          ref_grid[i][y][x] = 1'b0;
      ref_gen[i] = 0;
      ref_pop[i] = 0;
    end
  endfunction

  function automatic void model_seed(input int x, input int y, input bit v);
    for (int i = 0; i < 2; i++) ref_grid[i][y][x] = v;
  endfunction

  function automatic void model_step();
    bit nxt [H][W];
    int live, n, px, py;
    for (int i = 0; i < 2; i++) begin
      live = 0;
      for (int y = 0; y < H; y++) begin
        for (int x = 0; x < W; x++) begin
          n = 0;
          for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
              if (dx != 0 || dy != 0) begin
                px = x + dx;
                py = y + dy;
                if (i == 0) begin
                  px = (px + W) % W;
                  py = (py + H) % H;
                  n += int'(ref_grid[i][py][px]);
                end else if (px >= 0 && px < W && py >= 0 && py < H) begin
                  n += int'(ref_grid[i][py][px]);
                end
              end
            end
          end
          nxt[y][x] = (n == 3) || (ref_grid[i][y][x] && n == 2);
          live += int'(nxt[y][x]);
        end
      end
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          ref_grid[i][y][x] = nxt[y][x];
      ref_pop[i] = live;
      ref_gen[i] = (ref_gen[i] + 1) % 65536;
    end
  endfunction

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
  endtask

  task automatic seed_cell(input int x, input int y, input bit v);
    seed_x   = 4'(x);
    seed_y   = 4'(y);
    seed_val = v;
    seed_we  = 1'b1;
    tick();
    seed_we  = 1'b0;
    model_seed(x, y, v);
  endtask

  // Waits (bounded) for the commit cycle, then lets the commit edge land.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!gen_done_w && cycles < 600) begin
      tick();
      cycles++;
    end
    checkOutput("gen_done seen wrap", int'(gen_done_w), 1);
    checkOutput("gen_done seen nowrap", int'(gen_done_n), 1);
    tick();
    model_step();
  endtask

  task automatic run_step(output int latency);
    int c;
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_done(c);
    latency = c + 1;
  endtask

  task automatic check_status(input string name);
    checkOutput({name, " generation wrap"}, int'(generation_w), ref_gen[0]);
    checkOutput({name, " generation nowrap"}, int'(generation_n), ref_gen[1]);
    checkOutput({name, " pop wrap"}, int'(pop_w), ref_pop[0]);
    checkOutput({name, " pop nowrap"}, int'(pop_n), ref_pop[1]);
  endtask

  task automatic check_grid(input string name);
    int errs_w, errs_n;
    errs_w = 0;
    errs_n = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        rd_x = 4'(x);
        rd_y = 4'(y);
        tick();
        if (rd_alive_w != ref_grid[0][y][x]) errs_w++;
        if (rd_alive_n != ref_grid[1][y][x]) errs_n++;
      end
    end
    checkOutput({name, " grid cells wrong wrap"}, errs_w, 0);
    checkOutput({name, " grid cells wrong nowrap"}, errs_n, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int lat;
    do_clear();
    for (int k = 0; k < v.ncells; k++)
      seed_cell(int'(v.cells[k*8+4 +: 4]), int'(v.cells[k*8 +: 4]), 1'b1);
    for (int s = 0; s < v.steps; s++) begin
      run_step(lat);
      checkOutput({v.name, " gen_done latency"}, lat, 257);
    end
  endtask

  task automatic seed_blinker();
    seed_cell(5, 4, 1'b1);
    seed_cell(5, 5, 1'b1);
    seed_cell(5, 6, 1'b1);
  endtask

  initial begin
    int lat, gd, c;
    int gx [5];
    int gy [5];

    // cells byte = {x, y}; entry k lives in bits [8k+7:8k]
    vecs[0] = '{"blinker",     3, {8'h00, 8'h00, 8'h56, 8'h55, 8'h54}, 1, 3, 3};
    vecs[1] = '{"blinker x2",  3, {8'h00, 8'h00, 8'h56, 8'h55, 8'h54}, 2, 3, 3};
    vecs[2] = '{"corners",     4, {8'h00, 8'hFF, 8'h0F, 8'hF0, 8'h00}, 1, 4, 0};
    vecs[3] = '{"block",       4, {8'h00, 8'h33, 8'h23, 8'h32, 8'h22}, 1, 4, 4};
    vecs[4] = '{"lone cell",   1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h77}, 1, 0, 0};
    vecs[5] = '{"edge blinker",3, {8'h00, 8'h00, 8'hF8, 8'h18, 8'h08}, 1, 3, 0};
    vecs[6] = '{"glider",      5, {8'h33, 8'h23, 8'h13, 8'h32, 8'h21}, 1, 5, 5};

    reset = 1'b1; step = 1'b0; run = 1'b0; gen_tick = 1'b0; clear = 1'b0;
    seed_we = 1'b0; seed_val = 1'b0; seed_x = '0; seed_y = '0; rd_x = '0; rd_y = '0;
    model_clear();
    repeat (3) tick();
    checkOutput("reset busy", int'(busy_w), 0);
    checkOutput("reset gen_done", int'(gen_done_w), 0);
    checkOutput("reset generation", int'(generation_w), 0);
    checkOutput("reset pop", int'(pop_w), 0);
    checkOutput("reset rd_alive", int'(rd_alive_w), 0);
    reset = 1'b0;
    tick();

    gen_tick = 1'b1;
    tick();
    gen_tick = 1'b0;
    checkOutput("gen_tick without run busy", int'(busy_w), 0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, " pop wrap table"}, int'(pop_w), vecs[i].pop_wrap);
      checkOutput({vecs[i].name, " pop nowrap table"}, int'(pop_n), vecs[i].pop_nowrap);
      checkOutput({vecs[i].name, " generation table"}, int'(generation_w), vecs[i].steps);
      check_status(vecs[i].name);
      check_grid(vecs[i].name);
    end

    // Seed and step in the same cycle: the start is lost unless step is held.
    do_clear();
    seed_x = 4'd4; seed_y = 4'd4; seed_val = 1'b1; seed_we = 1'b1; step = 1'b1;
    tick();
    seed_we = 1'b0; step = 1'b0;
    model_seed(4, 4, 1'b1);
    tick();
    checkOutput("seed+step start dropped busy", int'(busy_w), 0);
    seed_x = 4'd4; seed_y = 4'd5; seed_we = 1'b1; step = 1'b1;
    tick();
    seed_we = 1'b0;
    model_seed(4, 5, 1'b1);
    tick();
    step = 1'b0;
    checkOutput("held step taken busy", int'(busy_w), 1);
    wait_done(c);
    checkOutput("held step commit distance", c, 256);
    check_status("held step");
    check_grid("held step");

    // Step and seed while busy are both dropped.
    do_clear();
    seed_blinker();
    gd = 0;
    step = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      step = 1'b0;
      seed_we = 1'b0;
      if (gen_done_w) gd++;
      if (k == 100) begin
        checkOutput("busy at drop point", int'(busy_w), 1);
        step = 1'b1; seed_we = 1'b1; seed_x = 4'd3; seed_y = 4'd3; seed_val = 1'b1;
      end
    end
    model_step();
    checkOutput("busy drop gen_done count", gd, 1);
    check_status("busy drop");
    check_grid("busy drop");

    // Clear mid-generation, starting from generation 1 so the reset of the count shows.
    seed_cell(8, 8, 1'b1);
    seed_cell(9, 8, 1'b1);
    seed_cell(10, 8, 1'b1);
    step = 1'b1;
    for (int k = 1; k <= 49; k++) begin
      tick();
      step = 1'b0;
    end
    checkOutput("busy before clear", int'(busy_w), 1);
    checkOutput("pop before clear", int'(pop_w), 3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    checkOutput("busy after clear wrap", int'(busy_w), 0);
    checkOutput("busy after clear nowrap", int'(busy_n), 0);
    gd = 0;
    repeat (300) begin
      tick();
      if (gen_done_w || gen_done_n) gd++;
    end
    checkOutput("gen_done after abort", gd, 0);
    check_status("clear mid-gen");
    check_grid("clear mid-gen");

    // Async reset in the middle of COMPUTE.
    do_clear();
    seed_blinker();
    run_step(lat);
    rd_x = 4'd5; rd_y = 4'd5;
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (30) tick();
    checkOutput("pre-reset busy", int'(busy_w), 1);
    checkOutput("pre-reset rd_alive", int'(rd_alive_w), 1);
    checkOutput("pre-reset generation", int'(generation_w), 1);
    #3 reset = 1'b1;
    #1;
    checkOutput("async reset busy wrap", int'(busy_w), 0);
    checkOutput("async reset busy nowrap", int'(busy_n), 0);
    checkOutput("async reset gen_done", int'(gen_done_w), 0);
    checkOutput("async reset rd_alive", int'(rd_alive_w), 0);
    checkOutput("async reset generation", int'(generation_w), 0);
    @(posedge board_clk);
    #2 reset = 1'b0;
    tick();
    model_clear();
    check_status("after reset");
    check_grid("after reset");

    // Random soups against the model.
    for (int it = 0; it < 6; it++) begin
      do_clear();
      repeat (60) seed_cell(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                            1'($urandom_range(0, 1)));
      for (int s = 0; s < 1 + (it % 2); s++) begin
        run_step(lat);
        checkOutput("random gen_done latency", lat, 257);
      end
      check_status("random");
      check_grid("random");
    end

    // Glider free-running through the wrap: back home after 64 generations.
    gx = '{15, 0, 14, 15, 0};
    gy = '{14, 15, 0, 0, 0};
    do_clear();
    for (int k = 0; k < 5; k++) seed_cell(gx[k], gy[k], 1'b1);
    run = 1'b1;
    for (int g = 0; g < 64; g++) begin
      gen_tick = 1'b1;
      tick();
      gen_tick = 1'b0;
      wait_done(c);
      checkOutput("glider commit distance", c, 256);
      checkOutput("glider pop wrap", int'(pop_w), 5);
      checkOutput("glider pop nowrap", int'(pop_n), ref_pop[1]);
      repeat (300 - c - 2) tick();
    end
    run = 1'b0;
    checkOutput("glider generation", int'(generation_w), 64);
    check_status("glider");
    check_grid("glider");
    for (int k = 0; k < 5; k++) begin
      rd_x = 4'(gx[k]);
      rd_y = 4'(gy[k]);
      tick();
      checkOutput("glider home cell", int'(rd_alive_w), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/conway_life_engine.md
Name: conway_life_engine

Overview:
Parametrised Game of Life core that replaces the fixed, combinationally initialised cell matrix in the VGA top level. It holds a W x H cell grid in registers and accepts cell seeding and clear commands. It computes successive generations with one cell evaluated per clock, with toroidal or dead-boundary edges. A registered pixel-lookup read port feeds the VGA colour logic.

Parameters:
W, 16, grid width in cells (>=3)
H, 16, grid height in cells (>=3)
WRAP, 1, 1 = toroidal edges; 0 = off-grid neighbours count as dead
XW, $clog2(W), x coordinate width (derived)
YW, $clog2(H), y coordinate width (derived)

Ports:
board_clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
step  in  1  one-cycle pulse: compute one generation
run  in  1  level: free-run enable
gen_tick  in  1  one-cycle pulse from the divider; starts a generation when run=1
clear  in  1  one-cycle pulse: kill all cells
seed_we  in  1  write one cell of the current grid
seed_x / seed_y  in  XW / YW  seed coordinates
seed_val  in  1  value to write
rd_x / rd_y  in  XW / YW  display lookup coordinates
rd_alive  out  1  registered state of the current-grid cell at (rd_x, rd_y)
busy  out  1  generation in progress
gen_done  out  1  one-cycle pulse on commit
generation  out  16  generation count, wraps at 65535->0
pop_count  out  XW+YW+1  live cells in the last committed or cleared grid

Behaviour:
- Storage: cur[W*H] and nxt[W*H] flat vectors. Index = y*W + x.
- Reset (async): cur=0, nxt=0, state=IDLE, scan x=y=0, rd_alive=0, busy=0, gen_done=0, generation=0, pop_count=0.
- States:
  - IDLE: busy=0.
    - start = step | (run & gen_tick).
    - On start -> COMPUTE with scan (0,0) and pop accumulator=0.
  - COMPUTE: busy=1.
    - Each cycle, evaluate cell (x,y): n = count of the 8 neighbours in cur.
    - nxt[idx] = (n==3) | (cur[idx] & n==2). Add that result to the accumulator.
    - Scan is x-major: x increments; at x=W-1, x=0 and y increments.
    - After evaluating (W-1,H-1) -> COMMIT.
  - COMMIT: busy=1, gen_done=1 for this cycle.
    - cur<=nxt, generation<=generation+1, pop_count<=accumulator.
    - Next state IDLE.
- Latency: start sampled at edge k. Cells are evaluated on edges k+1..k+W*H. COMMIT is registered at edge k+W*H+1. New cur is visible to rd_alive at edge k+W*H+2.
- Neighbour edges:
  - WRAP=1: coordinates are taken modulo W/H. x-1 at x=0 is W-1; x+1 at W-1 is 0; same for y.
  - WRAP=0: neighbours outside 0..W-1 / 0..H-1 contribute 0.
- Priority per cycle: clear > seed_we > start.
  - clear in any state: cur=0, pop_count=0, state=IDLE, scan reset, busy=0. generation is reset to 0. An in-progress generation is aborted with no gen_done.
  - seed_we is accepted only in IDLE and only when clear=0.
    - Writes cur[seed_y*W+seed_x] = seed_val.
    - Out-of-range coordinates are ignored.
    - A seed in the same cycle as start is applied, and start is taken on the following cycle only if step/gen_tick is still high (otherwise dropped).
    - pop_count is not updated by seeding.
  - step/gen_tick while busy: ignored, not queued.
  - seed_we while busy: dropped; cur is unchanged.
- Read port: rd_alive <= cur[rd_y*W+rd_x] each edge (1-cycle latency). Out-of-range coordinates give 0. During COMPUTE it reads the old cur, so the display never shows a partial generation.
- Arithmetic: neighbour count is 4 bits. The accumulator and pop_count are XW+YW+1 bits, which are sufficient for W*H.

Test Plan:
- Blinker (W=H=16, WRAP=1): seed (5,4),(5,5),(5,6), pulse step -> gen_done exactly 257 cycles after step. Live cells are (4,5),(5,5),(6,5); generation=1, pop_count=3. A second step restores the vertical line, generation=2.
- Corner wrap: seed (0,0),(15,0),(0,15),(15,15). WRAP=1: after step all 4 remain, pop_count=4. WRAP=0 build: all die, pop_count=0.
- Glider wrap: seed a glider near (14,14), run=1 with gen_tick every 300 cycles. After 64 generations the glider returns to its seed pattern shifted (+16,+16), i.e. the original cells; pop_count=5 after every generation.
- Busy drops: pulse step, then step and seed_we (3,3,1) at cycle 100 -> exactly one gen_done, generation=1, and (3,3) is unaffected by the dropped seed.
- Clear mid-generation: step, then clear at cycle 50 -> busy=0 next cycle, no gen_done, all rd_alive=0, generation=0, pop_count=0.
- Async reset mid-COMPUTE: assert reset between edges -> busy, gen_done, rd_alive and generation are 0 immediately. After release, a read of every cell returns 0.
